// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader and the fetch-side word assembly.
package imem_loader_pkg;

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    localparam int BYTES_PER_WORD = 4;

    // Big-endian lane select: lane 0 is the MSB, stored at the lowest byte address.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_byte_serializer.sv
// Holds one captured instruction word and steps through its four big-endian byte lanes.
module imem_byte_serializer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] data,
    output logic [1:0]  idx,
    output logic [7:0]  byte_data,
    output logic        last_byte
);

    logic [31:0] word_reg;

    // A new word always restarts at lane 0; the index wraps naturally after the last lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg <= '0;
            idx      <= '0;
        end else if (load) begin
            word_reg <= data;
            idx      <= '0;
        end else if (advance) begin
            idx <= idx + 2'd1;
        end
    end

    assign byte_data = byte_lane(word_reg, idx);
    assign last_byte = (idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit program words into the instruction memory as four big-endian byte writes each.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_WORD = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            state, state_next;
    logic [ADDR_W-1:0] cur_addr, addr_next;
    logic [ADDR_W-1:0] remaining, rem_next;
    logic              err_next;
    logic              load;
    logic [1:0]        idx;
    logic [7:0]        byte_data;
    logic              last_byte;

    imem_byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (state == WRITE),
        .data      (in_data),
        .idx       (idx),
        .byte_data (byte_data),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cur_addr  <= addr_next;
            remaining <= rem_next;
            err       <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = cur_addr;
        rem_next   = remaining;
        err_next   = err;
        load       = 1'b0;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_next  = {base_addr[ADDR_W-1:2], 2'b00};
                    rem_next   = word_count;
                    err_next   = 1'b0;
                    state_next = (word_count == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cur_addr + ADDR_W'(idx);
                mem_wdata = byte_data;
                // Finishing the top aligned word with words still pending aborts rather than wrapping to 0.
                if (last_byte) begin
                    addr_next = cur_addr + ADDR_W'(BYTES_PER_WORD);
                    rem_next  = remaining - 1'b1;
                    if (remaining == ADDR_W'(1)) begin
                        state_next = DONE;
                    end else if (cur_addr == LAST_WORD) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = ACCEPT;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a byte-array memory model and big-endian fetch readback.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_bytes [4];
    int          errors = 0;
    int          checks = 0;
    int          we_count = 0;
    int          done_count = 0;
    int          we_base;
    int          done_base;
    logic        wrote_zero = 1'b0;

    imem_loader #(.ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Memory model: commits each byte write on the edge, like the real write port.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            we_count++;
            if (mem_addr == 16'h0000) wrote_zero = 1'b1;
        end
        if (done) done_count++;
    end

    function automatic logic [31:0] fetch(input logic [15:0] a);
        return {mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, expected);
        end
    endtask

    // Pulses start for one cycle; returns just after the edge that sampled it.
    task automatic applyStimulus(input logic [15:0] base, input logic [15:0] count,
                                 input logic valid, input logic [31:0] data);
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = base;
        word_count = count;
        in_valid   = valid;
        in_data    = data;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitReady();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 200);
        if (!in_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 200);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic feedWords(input logic [31:0] w0, input logic [31:0] w1, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap > 0) begin
                in_valid = 1'b0;
                waitReady();
                for (int g = 0; g < gap; g++) begin
                    if (g > 0) @(negedge clk);
                    checkOutput("gap_ready", 32'(in_ready), 32'd1);
                    checkOutput("gap_we", 32'(mem_we), 32'd0);
                end
                @(posedge clk); #1;
            end
            in_data  = (i == 0) ? w0 : w1;
            in_valid = 1'b1;
            waitReady();
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = 32'hDEADBEEF;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        exp_bytes  = '{8'h8C, 8'h22, 8'h00, 8'h04};
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_busy_done_err", 32'({busy, done, err}), 32'd0);
        checkOutput("rst_addr_data", {8'h00, mem_addr, mem_wdata}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] single word at 0x10");
        we_base = we_count; done_base = done_count;
        applyStimulus(16'h0010, 16'd1, 1'b1, 32'h8C220004);
        @(negedge clk);
        checkOutput("t1_accept_ready", 32'(in_ready), 32'd1);
        checkOutput("t1_accept_busy", 32'(busy), 32'd1);
        checkOutput("t1_accept_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t1_we", 32'(mem_we), 32'd1);
            checkOutput("t1_addr", 32'(mem_addr), 32'h10 + 32'(i));
            checkOutput("t1_data", 32'(mem_wdata), 32'(exp_bytes[i]));
            checkOutput("t1_ready_low", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("t1_done_pulse", 32'(done), 32'd0);
        checkOutput("t1_fetch", fetch(16'h0010), 32'h8C220004);
        checkOutput("t1_we_count", 32'(we_count - we_base), 32'd4);
        checkOutput("t1_done_count", 32'(done_count - done_base), 32'd1);

        $display("[TB] unaligned base 0x13, two words");
        we_base = we_count;
        applyStimulus(16'h0013, 16'd2, 1'b0, 32'h0);
        feedWords(32'h11111111, 32'h22222222, 2, 0);
        waitDone("t2");
        checkOutput("t2_err", 32'(err), 32'd0);
        checkOutput("t2_fetch0", fetch(16'h0010), 32'h11111111);
        checkOutput("t2_fetch1", fetch(16'h0014), 32'h22222222);
        checkOutput("t2_we_count", 32'(we_count - we_base), 32'd8);

        $display("[TB] three idle cycles between words");
        we_base = we_count;
        applyStimulus(16'h0040, 16'd2, 1'b0, 32'h0);
        feedWords(32'hA1B2C3D4, 32'h55AA0FF0, 2, 3);
        waitDone("t3");
        checkOutput("t3_fetch0", fetch(16'h0040), 32'hA1B2C3D4);
        checkOutput("t3_fetch1", fetch(16'h0044), 32'h55AA0FF0);
        checkOutput("t3_we_count", 32'(we_count - we_base), 32'd8);

        $display("[TB] overflow at top of memory");
        we_base = we_count;
        applyStimulus(16'hFFFC, 16'd2, 1'b0, 32'h0);
        feedWords(32'hCAFEF00D, 32'h0, 1, 0);
        waitDone("t4");
        checkOutput("t4_err", 32'(err), 32'd1);
        checkOutput("t4_fetch", fetch(16'hFFFC), 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("t4_err_sticky", 32'(err), 32'd1);
        checkOutput("t4_ready_idle", 32'(in_ready), 32'd0);
        checkOutput("t4_we_count", 32'(we_count - we_base), 32'd4);
        checkOutput("t4_no_wrap", 32'(wrote_zero), 32'd0);

        $display("[TB] zero word count");
        we_base = we_count; done_base = done_count;
        applyStimulus(16'h0100, 16'd0, 1'b1, 32'h12121212);
        @(negedge clk);
        checkOutput("t5_done", 32'(done), 32'd1);
        checkOutput("t5_err_cleared", 32'(err), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t5_we_count", 32'(we_count - we_base), 32'd0);
        checkOutput("t5_done_count", 32'(done_count - done_base), 32'd1);

        $display("[TB] reset mid-load, reload, start while busy");
        applyStimulus(16'h0080, 16'd1, 1'b1, 32'h12345678);
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("t6_byte0_addr", 32'(mem_addr), 32'h80);
        @(negedge clk);
        checkOutput("t6_byte1_addr", 32'(mem_addr), 32'h81);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_outs", 32'({in_ready, mem_we, busy, done, err}), 32'd0);
        checkOutput("t6_rst_addr_data", {8'h00, mem_addr, mem_wdata}, 32'd0);
        checkOutput("t6_kept_bytes", 32'({mem[16'h0080], mem[16'h0081]}), 32'h1234);
        checkOutput("t6_no_byte2", 32'(mem[16'h0082]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        we_base = we_count; done_base = done_count;
        applyStimulus(16'h0080, 16'd1, 1'b0, 32'h0);
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = 16'h0200;
        word_count = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        feedWords(32'h9ABCDEF0, 32'h0, 1, 0);
        waitDone("t6");
        checkOutput("t6_fetch", fetch(16'h0080), 32'h9ABCDEF0);
        checkOutput("t6_untouched", fetch(16'h0200), 32'h0);
        @(negedge clk);
        checkOutput("t6_idle_busy", 32'(busy), 32'd0);
        checkOutput("t6_idle_ready", 32'(in_ready), 32'd0);
        checkOutput("t6_we_count", 32'(we_count - we_base), 32'd4);
        checkOutput("t6_done_count", 32'(done_count - done_base), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
